// File: rtl/issue_scoreboard_pkg.sv
// Shared types for the issue-stage scoreboard.
// Provides the register tag and word types, the scoreboard slot entry and
// the default pipeline depth from issue to writeback.
package issue_scoreboard_pkg;

    typedef logic [4:0]  tag_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        logic valid;
        tag_t rd;
    } sb_entry_t;

    // Cycles from issue to the writeback stage.
    localparam int unsigned SB_DEPTH = 3;

endpackage

// File: rtl/sb_slot_match.sv
// Hazard compare for one scoreboard slot.
// Ports:
//   entry_i          slot contents {valid, rd}
//   rs1_i, rs2_i     source tags of the decode instruction
//   use_rs1_i/_rs2_i source is actually read
//   hit_o            slot holds a pending write to a used source
module sb_slot_match
    import issue_scoreboard_pkg::*;
(
    input  sb_entry_t entry_i,
    input  tag_t      rs1_i,
    input  tag_t      rs2_i,
    input  logic      use_rs1_i,
    input  logic      use_rs2_i,
    output logic      hit_o
);

    // x0 is never allocated, so tag 0 cannot match a valid slot.
    always_comb begin
        hit_o = entry_i.valid &
                ((use_rs1_i & (entry_i.rd == rs1_i)) |
                 (use_rs2_i & (entry_i.rd == rs2_i)));
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue-stage hazard scheduler.
// Tracks destination tags from issue until the writeback stage (slot DEPTH-1),
// holds decode on a RAW hazard and purges wrong-path slots on a redirect.
// Ports:
//   clock, reset        clock and synchronous active-high reset
//   issue_*             decode instruction: valid, sources, use bits, rd, writes_rd
//   redirect            writeback resolved a taken control transfer this cycle
//   issue_ready         decode instruction may advance
//   busy_mask           bit r set while register r has a pending write
//   inflight            number of valid slots
//   stall_count         saturating count of hazard-stall cycles
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned CNT_W = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       issue_valid,
    input  tag_t                       issue_rs1,
    input  tag_t                       issue_rs2,
    input  logic                       issue_use_rs1,
    input  logic                       issue_use_rs2,
    input  tag_t                       issue_rd,
    input  logic                       issue_writes_rd,
    input  logic                       redirect,
    output logic                       issue_ready,
    output word_t                      busy_mask,
    output logic [$clog2(DEPTH+1)-1:0] inflight,
    output logic [CNT_W-1:0]           stall_count
);

    localparam int unsigned IW = $clog2(DEPTH + 1);

    sb_entry_t        slots [DEPTH];
    logic [DEPTH-1:0] hits;
    logic             hazard;
    logic             alloc;
    sb_entry_t        new_entry;

    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        sb_slot_match u_match (
            .entry_i   (slots[g]),
            .rs1_i     (issue_rs1),
            .rs2_i     (issue_rs2),
            .use_rs1_i (issue_use_rs1),
            .use_rs2_i (issue_use_rs2),
            .hit_o     (hits[g])
        );
    end

    always_comb begin
        hazard          = |hits;
        issue_ready     = ~hazard & ~redirect;
        alloc           = issue_valid & issue_ready & issue_writes_rd & (issue_rd != '0);
        new_entry.valid = alloc;
        new_entry.rd    = alloc ? issue_rd : '0;
    end

    always_comb begin
        busy_mask = '0;
        inflight  = '0;
        for (int unsigned s = 0; s < DEPTH; s++) begin
            if (slots[s].valid) begin
                busy_mask[slots[s].rd] = 1'b1;
            end
            inflight = inflight + IW'(slots[s].valid);
        end
    end

    // The shift never stalls. On a redirect every slot younger than writeback
    // is wrong-path, so nothing moves forward; the writeback slot retires.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned s = 0; s < DEPTH; s++) begin
                slots[s] <= '0;
            end
            stall_count <= '0;
        end else begin
            slots[0] <= new_entry;
            for (int unsigned s = 1; s < DEPTH; s++) begin
                slots[s] <= redirect ? '0 : slots[s-1];
            end
            if (issue_valid && hazard && !redirect && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule
